// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multicycle MIPS controller (master) and the datapath (slave).
interface mc_control_fsm_if;
    logic [5:0] Op;
    logic       Zero;
    logic       memReady;
    logic       MemRead;
    logic       MemWrite;
    logic       IorD;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PcSrc;
    logic       PcEn;
    logic       Illegal;
    logic       BusErr;
    logic [3:0] State;

    modport master (
        input  Op, Zero, memReady,
        output MemRead, MemWrite, IorD, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUOp, PcSrc, PcEn, Illegal, BusErr, State
    );

    modport slave (
        output Op, Zero, memReady,
        input  MemRead, MemWrite, IorD, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUOp, PcSrc, PcEn, Illegal, BusErr, State
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute, resolves PC enable
// (beq/bne polarity) and aborts memory states that wait longer than TIMEOUT cycles.
module mc_control_fsm #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mc_control_fsm_if.master       bus
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       is_bne_q, is_bne_d;
    // Held low from reset until the first clock edge so every output stays 0 in that gap.
    logic       active_q, active_d;

    logic       mem_read, mem_write, iord, ir_write, reg_dst, mem_to_reg, reg_write;
    logic       alu_src_a, pc_en, illegal, bus_err;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic       timed_out;

    assign timed_out = (wait_q == TIMEOUT_CNT) && !bus.memReady;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_FETCH;
            wait_q   <= '0;
            is_bne_q <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            is_bne_q <= is_bne_d;
            active_q <= active_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_d     = '0;
        is_bne_d   = is_bne_q;
        active_d   = 1'b1;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_src     = 2'b00;
        pc_en      = 1'b0;
        illegal    = 1'b0;
        bus_err    = 1'b0;

        if (!active_q) begin
            state_d = S_FETCH;
        end else begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    if (bus.memReady) begin
                        ir_write = 1'b1;
                        pc_en    = 1'b1;
                        state_d  = S_DECODE;
                    end else if (timed_out) begin
                        bus_err = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        wait_d = wait_q + 8'd1;
                    end
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    is_bne_d  = (bus.Op == OP_BNE);
                    case (bus.Op)
                        OP_LW, OP_SW:   state_d = S_MEMADR;
                        OP_RTYPE:       state_d = S_EXEC;
                        OP_BEQ, OP_BNE: state_d = S_BRANCH;
                        OP_ADDI:        state_d = S_ADDIEX;
                        OP_J:           state_d = S_JUMP;
                        default: begin
                            illegal = 1'b1;
                            state_d = S_FETCH;
                        end
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    state_d   = (bus.Op == OP_SW) ? S_MEMWR : S_MEMRD;
                end
                S_MEMRD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                    if (bus.memReady) begin
                        state_d = S_MEMWB;
                    end else if (timed_out) begin
                        bus_err = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        wait_d = wait_q + 8'd1;
                    end
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    state_d    = S_FETCH;
                end
                S_MEMWR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                    if (bus.memReady) begin
                        state_d = S_FETCH;
                    end else if (timed_out) begin
                        bus_err = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        wait_d = wait_q + 8'd1;
                    end
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                    state_d   = S_ALUWB;
                end
                S_ALUWB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                    state_d   = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b01;
                    pc_src    = 2'b01;
                    pc_en     = is_bne_q ? ~bus.Zero : bus.Zero;
                    state_d   = S_FETCH;
                end
                S_ADDIEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    state_d   = S_ADDIWB;
                end
                S_ADDIWB: begin
                    reg_write = 1'b1;
                    state_d   = S_FETCH;
                end
                S_JUMP: begin
                    pc_src  = 2'b10;
                    pc_en   = 1'b1;
                    state_d = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    assign bus.MemRead  = mem_read;
    assign bus.MemWrite = mem_write;
    assign bus.IorD     = iord;
    assign bus.IRWrite  = ir_write;
    assign bus.RegDst   = reg_dst;
    assign bus.MemtoReg = mem_to_reg;
    assign bus.RegWrite = reg_write;
    assign bus.ALUSrcA  = alu_src_a;
    assign bus.ALUSrcB  = alu_src_b;
    assign bus.ALUOp    = alu_op;
    assign bus.PcSrc    = pc_src;
    assign bus.PcEn     = pc_en;
    assign bus.Illegal  = illegal;
    assign bus.BusErr   = bus_err;
    assign bus.State    = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: directed vector table, multi-cycle corner sequences,
// then random instruction streams checked against an instruction-level model.
module tb_mc_control_fsm;

    localparam int TO = 15;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] BNE  = 6'b000101;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] ILL  = 6'b111111;

    // Output bundle bit positions: {MemRead,MemWrite,IorD,IRWrite,RegDst,MemtoReg,RegWrite,
    // ALUSrcA,ALUSrcB[1:0],ALUOp[1:0],PcSrc[1:0],PcEn,Illegal,BusErr}
    localparam logic [16:0] B_IRW = 17'd1 << 13;
    localparam logic [16:0] B_RW  = 17'd1 << 10;
    localparam logic [16:0] B_PE  = 17'd1 << 2;
    localparam logic [16:0] B_ILL = 17'd1 << 1;
    localparam logic [16:0] B_BE  = 17'd1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mc_control_fsm_if bus();

    mc_control_fsm #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [5:0]  op;
        logic        zero;
        logic        mr;
        logic [3:0]  st;
        logic [16:0] out;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [16:0] o(input logic mr, mw, iord, irw, rd, m2r, rw, sa,
                                      input logic [1:0] sb, aop, ps,
                                      input logic pe, ill, be);
        return {mr, mw, iord, irw, rd, m2r, rw, sa, sb, aop, ps, pe, ill, be};
    endfunction

    // State-only outputs of each state, before any memReady/Zero/Op-dependent terms.
    function automatic logic [16:0] moore(input int st);
        case (st)
            0:  return o(1,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0,0);
            1:  return o(0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0,0);
            2:  return o(0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0,0);
            3:  return o(1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,0);
            4:  return o(0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0,0,0);
            5:  return o(0,1,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,0);
            6:  return o(0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,0,0);
            7:  return o(0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0,0,0);
            8:  return o(0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0,0,0);
            9:  return o(0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0,0);
            10: return o(0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0,0,0);
            11: return o(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1,0,0);
            default: return 17'd0;
        endcase
    endfunction

    function automatic logic [16:0] got_out();
        return {bus.MemRead, bus.MemWrite, bus.IorD, bus.IRWrite, bus.RegDst, bus.MemtoReg,
                bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PcSrc, bus.PcEn,
                bus.Illegal, bus.BusErr};
    endfunction

    function automatic bit legal(input logic [5:0] op);
        return op inside {LW, SW, RT, BEQ, BNE, ADDI, JMP};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic add(input logic [5:0] op, input logic zero, input logic mr,
                       input int st, input logic [16:0] out);
        vec_t v;
        v.op = op; v.zero = zero; v.mr = mr; v.st = 4'(st); v.out = out;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic [5:0] op, input logic zero, input logic mr);
        bus.Op = op; bus.Zero = zero; bus.memReady = mr;
    endtask

    task automatic step(input logic [5:0] op, input logic zero, input logic mr);
        @(negedge clk);
        drive(op, zero, mr);
        #1;
    endtask

    // Ends on the first rising edge after release; the next negedge is the first FETCH cycle.
    task automatic do_reset();
        rst_n = 1'b0;
        drive(6'd0, 1'b0, 1'b1);
        #1;
        check("in_reset_outs", 32'(got_out()), 32'd0);
        check("in_reset_state", 32'(bus.State), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_outs", 32'(got_out()), 32'd0);
        check("release_state", 32'(bus.State), 32'd0);
        @(posedge clk);
    endtask

    // Instruction-level reference model state
    int          cur;
    int          wt;
    int          pq[$];
    int          stall;
    logic [5:0]  rop;
    logic        rz, rmr;
    logic [16:0] e;
    bit          adv, abort_i;
    int          rsel;
    logic [16:0] f_ok;

    initial begin
        rst_n = 1'b0;
        drive(6'd0, 1'b0, 1'b0);
        f_ok = moore(0) | B_IRW | B_PE;

        // lw, memReady ignored in MEMADR
        add(LW, 0, 1, 0, f_ok);
        add(LW, 0, 1, 1, moore(1));
        add(LW, 1, 0, 2, moore(2));
        add(LW, 0, 1, 3, moore(3));
        add(LW, 0, 1, 4, moore(4));
        // beq taken / not taken
        add(BEQ, 0, 1, 0, f_ok);
        add(BEQ, 0, 1, 1, moore(1));
        add(BEQ, 1, 1, 8, moore(8) | B_PE);
        add(BEQ, 0, 1, 0, f_ok);
        add(BEQ, 0, 1, 1, moore(1));
        add(BEQ, 0, 1, 8, moore(8));
        // bne: inverted polarity
        add(BNE, 0, 1, 0, f_ok);
        add(BNE, 0, 1, 1, moore(1));
        add(BNE, 1, 1, 8, moore(8));
        add(BNE, 0, 1, 0, f_ok);
        add(BNE, 0, 1, 1, moore(1));
        add(BNE, 0, 1, 8, moore(8) | B_PE);
        // fetch stalled 3 cycles, then illegal opcode
        add(ILL, 0, 0, 0, moore(0));
        add(ILL, 0, 0, 0, moore(0));
        add(ILL, 0, 0, 0, moore(0));
        add(ILL, 0, 1, 0, f_ok);
        add(ILL, 0, 1, 1, moore(1) | B_ILL);
        // sw with one wait cycle in MEMWR
        add(SW, 0, 1, 0, f_ok);
        add(SW, 0, 1, 1, moore(1));
        add(SW, 0, 1, 2, moore(2));
        add(SW, 0, 0, 5, moore(5));
        add(SW, 0, 1, 5, moore(5));
        // R-type
        add(RT, 0, 1, 0, f_ok);
        add(RT, 1, 0, 1, moore(1));
        add(RT, 1, 0, 6, moore(6));
        add(RT, 0, 0, 7, moore(7));
        // addi
        add(ADDI, 0, 1, 0, f_ok);
        add(ADDI, 0, 1, 1, moore(1));
        add(ADDI, 1, 0, 9, moore(9));
        add(ADDI, 0, 1, 10, moore(10));
        // j
        add(JMP, 0, 1, 0, f_ok);
        add(JMP, 1, 0, 1, moore(1));
        add(JMP, 1, 0, 11, moore(11));
        add(LW, 0, 0, 0, moore(0));

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].op, tbl[i].zero, tbl[i].mr);
            check($sformatf("tbl%0d_state", i), 32'(bus.State), 32'(tbl[i].st));
            check($sformatf("tbl%0d_out", i), 32'(got_out()), 32'(tbl[i].out));
        end

        // MEMRD timeout: BusErr on the 16th waiting cycle, then back to FETCH
        do_reset();
        step(LW, 0, 1);
        step(LW, 0, 1);
        step(LW, 0, 1);
        check("to_memadr_state", 32'(bus.State), 32'd2);
        for (int k = 1; k <= TO + 1; k++) begin
            step(LW, 0, 0);
            check($sformatf("to_state_k%0d", k), 32'(bus.State), 32'd3);
            check($sformatf("to_buserr_k%0d", k), 32'(bus.BusErr), 32'(k == TO + 1));
            check($sformatf("to_regwrite_k%0d", k), 32'(bus.RegWrite), 32'd0);
        end
        step(LW, 0, 0);
        check("to_after_state", 32'(bus.State), 32'd0);
        check("to_after_outs", 32'(got_out()), 32'(moore(0)));

        // Reset asserted mid-MEMWR drops MemWrite without a clock edge
        do_reset();
        step(SW, 0, 1);
        step(SW, 0, 1);
        step(SW, 0, 1);
        step(SW, 0, 0);
        check("memwr_active", 32'(bus.MemWrite), 32'd1);
        check("memwr_state", 32'(bus.State), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_memwrite", 32'(bus.MemWrite), 32'd0);
        check("async_rst_outs", 32'(got_out()), 32'd0);
        check("async_rst_state", 32'(bus.State), 32'd0);
        @(posedge clk);
        @(negedge clk);
        drive(LW, 0, 1);
        rst_n = 1'b1;
        #1;
        check("post_rel_outs", 32'(got_out()), 32'd0);
        check("post_rel_state", 32'(bus.State), 32'd0);
        step(LW, 0, 1);
        check("post_rel_fetch_outs", 32'(got_out()), 32'(f_ok));
        check("post_rel_fetch_state", 32'(bus.State), 32'd0);

        // Random instruction streams against the model
        do_reset();
        cur = 0; wt = 0; stall = 0; rop = LW;
        pq.delete();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (cur == 0) begin
                rsel = $urandom_range(0, 7);
                case (rsel)
                    0: rop = LW;
                    1: rop = SW;
                    2: rop = RT;
                    3: rop = BEQ;
                    4: rop = BNE;
                    5: rop = ADDI;
                    6: rop = JMP;
                    default: rop = 6'($urandom_range(0, 63));
                endcase
            end
            rz = 1'($urandom_range(0, 1));
            if (stall > 0) begin
                rmr = 1'b0;
                stall--;
            end else if ($urandom_range(0, 39) == 0) begin
                stall = $urandom_range(5, 20);
                rmr = 1'b0;
            end else begin
                rmr = ($urandom_range(0, 3) != 0);
            end
            drive(rop, rz, rmr);
            #1;

            e = moore(cur);
            adv = 1'b1;
            abort_i = 1'b0;
            if (cur == 0 || cur == 3 || cur == 5) begin
                if (rmr) begin
                    if (cur == 0) e = e | B_IRW | B_PE;
                end else if (wt == TO) begin
                    e = e | B_BE;
                    abort_i = 1'b1;
                end else begin
                    wt++;
                    adv = 1'b0;
                end
            end
            if (cur == 1 && !legal(rop)) e = e | B_ILL;
            if (cur == 8 && ((rop == BNE) ? !rz : rz)) e = e | B_PE;

            check($sformatf("rnd%0d_state", c), 32'(bus.State), 32'(cur));
            check($sformatf("rnd%0d_out", c), 32'(got_out()), 32'(e));

            if (adv) begin
                wt = 0;
                if (abort_i) begin
                    pq.delete();
                    cur = 0;
                end else if (cur == 0) begin
                    pq.delete();
                    case (rop)
                        LW:       begin pq.push_back(2); pq.push_back(3); pq.push_back(4); end
                        SW:       begin pq.push_back(2); pq.push_back(5); end
                        RT:       begin pq.push_back(6); pq.push_back(7); end
                        BEQ, BNE: pq.push_back(8);
                        ADDI:     begin pq.push_back(9); pq.push_back(10); end
                        JMP:      pq.push_back(11);
                        default:  ;
                    endcase
                    cur = 1;
                end else if (pq.size() > 0) begin
                    cur = pq.pop_front();
                end else begin
                    cur = 0;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
